// File: rtl/prec_scalable_mac.sv
// Precision-scalable MAC: 1x8b, 2x4b or 4x2b weight lanes over four carry-chained segments.
// Optional build macro MAC_SAT_EN: clamp lane sums and report sat instead of wrapping.
module prec_scalable_mac #(
  parameter int ACT_W = 8,
  parameter int SEG_W = 14,
  localparam int RES_W = 4 * SEG_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic signed [ACT_W-1:0] act,
  input  logic [7:0]              wgt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        result,
  output logic                    mode_err,
  output logic                    sat
);

  localparam int W2 = RES_W / 2;
  localparam int W4 = RES_W / 4;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         frame_mode, beat_mode;
  logic               beat_acc, p_vld;
  logic [RES_W-1:0]   prod, prod_nxt, acc, acc_nxt;
  logic [3:0]         chain;
  logic               sat_hit;

  logic signed [ACT_W+7:0] m8;
  logic signed [ACT_W+3:0] m4 [2];
  logic signed [ACT_W+1:0] m2 [4];

  assign in_ready  = (state == IDLE) || (state == RUN);
  assign out_valid = (state == DONE);
  assign beat_acc  = in_valid && in_ready;
  assign beat_mode = (state == IDLE) ? mode : frame_mode;
  assign result    = acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat_acc) state_nxt = in_last ? FLUSH : RUN;
      RUN:     if (beat_acc && in_last) state_nxt = FLUSH;
      FLUSH:   if (!p_vld) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: per-lane products, sign-extended into the lane's slot of the segment vector
  always_comb begin
    prod_nxt = '0;
    m8 = act * $signed(wgt);
    for (int i = 0; i < 2; i++) m4[i] = act * $signed(wgt[4*i +: 4]);
    for (int i = 0; i < 4; i++) m2[i] = act * $signed(wgt[2*i +: 2]);
    case (beat_mode)
      2'b00:   prod_nxt = RES_W'(m8);
      2'b01:   for (int i = 0; i < 2; i++) prod_nxt[W2*i +: W2] = W2'(m4[i]);
      2'b10:   for (int i = 0; i < 4; i++) prod_nxt[W4*i +: W4] = W4'(m2[i]);
      default: prod_nxt = '0;
    endcase
  end

  // chain[j]: segment j takes the carry out of segment j-1 (same lane)
  always_comb begin
    case (frame_mode)
      2'b00:   chain = 4'b1110;
      2'b01:   chain = 4'b1010;
      default: chain = 4'b0000;
    endcase
  end

  // Stage 2: segmented add; a lane's sign lives in its top segment
  always_comb begin
    logic             carry;
    logic [SEG_W:0]   t;
    logic [SEG_W-1:0] a_s, p_s;
`ifdef MAC_SAT_EN
    logic [3:0]       is_top, ovf;
    logic             lane_ovf, lane_sgn;
`endif
    acc_nxt = acc;
    sat_hit = 1'b0;
    carry   = 1'b0;
    t       = '0;
`ifdef MAC_SAT_EN
    is_top   = {1'b1, ~chain[3:1]};
    ovf      = '0;
    lane_ovf = 1'b0;
    lane_sgn = 1'b0;
`endif
    for (int j = 0; j < 4; j++) begin
      a_s   = acc[j*SEG_W +: SEG_W];
      p_s   = prod[j*SEG_W +: SEG_W];
      t     = {1'b0, a_s} + {1'b0, p_s} + {{SEG_W{1'b0}}, chain[j] & carry};
      carry = t[SEG_W];
      acc_nxt[j*SEG_W +: SEG_W] = t[SEG_W-1:0];
`ifdef MAC_SAT_EN
      ovf[j] = is_top[j] && (a_s[SEG_W-1] == p_s[SEG_W-1]) && (t[SEG_W-1] != a_s[SEG_W-1]);
`endif
    end
`ifdef MAC_SAT_EN
    // Walk from the top so every segment sees its own lane's overflow and sign
    for (int j = 3; j >= 0; j--) begin
      if (is_top[j]) begin
        lane_ovf = ovf[j];
        lane_sgn = acc[j*SEG_W + SEG_W-1];
      end
      if (lane_ovf)
        acc_nxt[j*SEG_W +: SEG_W] = is_top[j] ? {lane_sgn, {(SEG_W-1){~lane_sgn}}}
                                              : {SEG_W{~lane_sgn}};
    end
    sat_hit = |ovf;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_vld      <= 1'b0;
      prod       <= '0;
      acc        <= '0;
      frame_mode <= 2'b00;
      mode_err   <= 1'b0;
    end else begin
      p_vld <= beat_acc;
      if (beat_acc) prod <= prod_nxt;
      if (beat_acc && state == IDLE) begin
        frame_mode <= mode;
        mode_err   <= (mode == 2'b11);
      end
      if (state == DONE && out_ready) acc <= '0;
      else if (p_vld)                 acc <= acc_nxt;
    end
  end

`ifdef MAC_SAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          sat <= 1'b0;
    else if (p_vld && sat_hit)          sat <= 1'b1;
    else if (beat_acc && state == IDLE) sat <= 1'b0;
  end
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_prec_scalable_mac.sv
// Bench for prec_scalable_mac: fixed vectors, corner sequences and randomized frames vs an arithmetic lane model.
module tb_prec_scalable_mac;
  localparam int ACT_W = 8;
  localparam int SEG_W = 14;
  localparam int RES_W = 4 * SEG_W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic signed [ACT_W-1:0] act = '0;
  logic [7:0] wgt = '0;
  logic in_ready, out_valid, mode_err, sat;
  logic [RES_W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [7:0] ba [80];
  logic [7:0] bw [80];

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  a;
    logic [7:0]  w;
    int          n;
    int          hold;
    logic [55:0] er;
    bit          ee;
    bit          es;
  } vec_t;
  vec_t tab [6];

  prec_scalable_mac #(.ACT_W(ACT_W), .SEG_W(SEG_W)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .act(act), .wgt(wgt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .mode_err(mode_err), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  // Lane sums straight from the arithmetic definition: signed slices, per-beat wrap or clamp
  function automatic logic [63:0] model(input logic [1:0] m, input int n, output bit s);
    int lanes, lw, sw;
    longint acc [4];
    longint a, sl, mx, mn;
    logic [63:0] r;
    s = 1'b0;
    r = '0;
    if (m == 2'b11) return r;
    lanes = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    lw = RES_W / lanes;
    sw = 8 / lanes;
    mx = (longint'(1) <<< (lw - 1)) - 1;
    mn = -mx - 1;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    for (int b = 0; b < n; b++) begin
      a = longint'($signed(ba[b]));
      for (int i = 0; i < lanes; i++) begin
        sl = longint'((bw[b] >> (i * sw)) & ((1 << sw) - 1));
        if (sl >= (longint'(1) <<< (sw - 1))) sl = sl - (longint'(1) <<< sw);
        acc[i] = acc[i] + wrapw(a * sl, lw);
`ifdef MAC_SAT_EN
        if (acc[i] > mx) begin acc[i] = mx; s = 1'b1; end
        else if (acc[i] < mn) begin acc[i] = mn; s = 1'b1; end
`else
        acc[i] = wrapw(acc[i], lw);
`endif
      end
    end
    for (int i = 0; i < lanes; i++)
      r = r | ((64'(acc[i]) & ((64'd1 << lw) - 1)) << (i * lw));
    return r;
  endfunction

  task automatic run_frame(input string nm, input logic [1:0] m, input int n, input bit bub,
                           input int hold, input logic [63:0] er, input bit ee, input bit es);
    int cyc;
    logic [63:0] held;
    out_ready = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (bub && b > 0 && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        act = ACT_W'($urandom);
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b1;
      act = ba[b];
      wgt = bw[b];
      in_last = (b == n - 1);
      mode = (b == 0) ? m : 2'($urandom);
      if (b == 0) chk({nm, "_rdy"}, 64'(in_ready), 64'd1);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk({nm, "_res"}, 64'(result), er);
    chk({nm, "_merr"}, 64'(mode_err), 64'(ee));
    chk({nm, "_sat"}, 64'(sat), 64'(es));
    held = 64'(result);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      act = ACT_W'($urandom);
      wgt = 8'($urandom);
      @(posedge clk); @(negedge clk);
      chk({nm, "_hold_res"}, 64'(result), held);
      chk({nm, "_hold_rdy"}, 64'(in_ready), 64'd0);
      chk({nm, "_hold_vld"}, 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle_vld"}, 64'(out_valid), 64'd0);
    chk({nm, "_idle_rdy"}, 64'(in_ready), 64'd1);
    chk({nm, "_idle_acc"}, 64'(result), 64'd0);
  endtask

  initial begin
    logic [63:0] er;
    bit es;
    logic [1:0] m;
    int n;

    tab[0] = '{2'b00, 8'hFD, 8'h05, 3, 5, 56'(-45), 1'b0, 1'b0};
    tab[1] = '{2'b01, 8'h07, 8'h3F, 1, 0, {28'(21), 28'(-7)}, 1'b0, 1'b0};
    tab[2] = '{2'b10, 8'h80, 8'hE4, 1, 0, {14'(128), 14'(256), 14'(-128), 14'(0)}, 1'b0, 1'b0};
    tab[3] = '{2'b11, 8'h05, 8'h07, 2, 0, 56'(0), 1'b1, 1'b0};
`ifdef MAC_SAT_EN
    tab[4] = '{2'b10, 8'h7F, 8'h40, 65, 0, {14'(8191), 42'(0)}, 1'b0, 1'b1};
`else
    tab[4] = '{2'b10, 8'h7F, 8'h40, 65, 0, {14'(-8129), 42'(0)}, 1'b0, 1'b0};
`endif
    tab[5] = '{2'b00, 8'h80, 8'h80, 2, 2, 56'(32768), 1'b0, 1'b0};

    #3;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_merr", 64'(mode_err), 64'd0);
    chk("rst_sat", 64'(sat), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 64'(in_ready), 64'd1);

    for (int t = 0; t < 6; t++) begin
      for (int b = 0; b < tab[t].n; b++) begin
        ba[b] = tab[t].a;
        bw[b] = tab[t].w;
      end
      run_frame($sformatf("vec%0d", t), tab[t].m, tab[t].n, 1'b0, tab[t].hold,
                64'(tab[t].er), tab[t].ee, tab[t].es);
    end

    // Reset in the middle of a frame, then a fresh single-beat frame
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; mode = 2'b00; act = 8'sd9; wgt = 8'd9; in_last = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midrst_pre", 64'(result), 64'd81);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_res", 64'(result), 64'd0);
    chk("midrst_vld", 64'(out_valid), 64'd0);
    chk("midrst_rdy", 64'(in_ready), 64'd1);
    chk("midrst_merr", 64'(mode_err), 64'd0);
    #1 rstn = 1'b1;
    @(negedge clk);
    ba[0] = 8'd2; bw[0] = 8'd3;
    run_frame("postrst", 2'b00, 1, 1'b0, 0, 64'd6, 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      m = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        ba[b] = 8'($urandom);
        bw[b] = 8'($urandom);
      end
      er = model(m, n, es);
`ifndef MAC_SAT_EN
      es = 1'b0;
`endif
      run_frame($sformatf("rnd%0d", f), m, n, 1'b1, $urandom_range(0, 2), er, (m == 2'b11), es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
